// File: rtl/ccd_readout_if.sv
// CCD readout sequencer bus: sensor clocks, ADC handshake and tx FIFO write port.
// The master side is the sequencer; the slave side is the sensor, ADC and FIFO.
interface ccd_readout_if;
    logic        ccd_toggle;
    logic        ccd_busy;
    logic        ccd_v1;
    logic        ccd_v2;
    logic        ccd_h1;
    logic        ccd_h2;
    logic        ccd_rg;
    logic        adc_sample;
    logic        adc_busy;
    logic [15:0] adc_data;
    logic        tx_wfull;
    logic        tx_winc;
    logic [7:0]  tx_wdata;

    modport master (
        input  ccd_toggle, adc_busy, adc_data, tx_wfull,
        output ccd_busy, ccd_v1, ccd_v2, ccd_h1, ccd_h2, ccd_rg,
        output adc_sample, tx_winc, tx_wdata
    );

    modport slave (
        output ccd_toggle, adc_busy, adc_data, tx_wfull,
        input  ccd_busy, ccd_v1, ccd_v2, ccd_h1, ccd_h2, ccd_rg,
        input  adc_sample, tx_winc, tx_wdata
    );
endinterface

// File: rtl/ccd_readout.sv
// Frame readout sequencer: clocks a CCD row by row, digitises each pixel and
// streams it to the tx FIFO as two bytes, low byte first.
module ccd_readout #(
    parameter int ROWS         = 520,
    parameter int COLS         = 796,
    parameter int PHASE_CYCLES = 8
) (
    input logic           clk,
    input logic           rst,
    ccd_readout_if.master bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW = $clog2(PHASE_CYCLES + 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(PHASE_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, V1, V2, RG, H1, SREQ, SWAIT, TX_LSB, TX_MSB, H2, DONE
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [15:0]   pixel_q, pixel_d;
    logic          phase_done;
    logic          timed;

    assign phase_done = (phase_q == PH_LAST);
    assign timed = state_q inside {V1, V2, RG, H1, H2};

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        pixel_d = pixel_q;
        unique case (state_q)
            IDLE: if (bus.ccd_toggle) begin
                state_d = V1;
                row_d   = '0;
                col_d   = '0;
            end
            V1: if (phase_done) state_d = V2;
            V2: if (phase_done) begin
                state_d = RG;
                col_d   = '0;
            end
            RG: if (phase_done) state_d = H1;
            H1: if (phase_done) state_d = SREQ;
            SREQ: if (bus.adc_busy) state_d = SWAIT;
            SWAIT: if (!bus.adc_busy) begin
                state_d = TX_LSB;
                pixel_d = bus.adc_data;
            end
            TX_LSB: if (!bus.tx_wfull) state_d = TX_MSB;
            TX_MSB: if (!bus.tx_wfull) state_d = H2;
            H2: if (phase_done) begin
                if (col_q < COL_LAST) begin
                    col_d   = col_q + 1'b1;
                    state_d = RG;
                end else if (row_q < ROW_LAST) begin
                    row_d   = row_q + 1'b1;
                    state_d = V1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Timer restarts on every state change so each phase is measured from entry.
        if (state_d != state_q || !timed) phase_d = '0;
        else                              phase_d = phase_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            row_q   <= '0;
            col_q   <= '0;
            pixel_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pixel_q <= pixel_d;
        end
    end

    logic tx_state;
    assign tx_state = (state_q == TX_LSB) || (state_q == TX_MSB);

    assign bus.ccd_busy   = (state_q != IDLE);
    assign bus.ccd_v1     = (state_q == V1);
    assign bus.ccd_v2     = (state_q == V2);
    assign bus.ccd_rg     = (state_q == RG);
    assign bus.ccd_h1     = (state_q == H1);
    assign bus.ccd_h2     = (state_q == H2);
    assign bus.adc_sample = (state_q == SREQ);
    assign bus.tx_winc    = tx_state && !bus.tx_wfull;
    assign bus.tx_wdata   = (state_q == TX_LSB) ? pixel_q[7:0]  :
                            (state_q == TX_MSB) ? pixel_q[15:8] : 8'h00;
endmodule
